cs_y_packer: RTL

//   Downstream stage of the CS smoothing filter. Consumes the 10-bit Y result

---
 rtl/cs_y_packer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cs_y_packer.sv
// Packs the 10-bit CS Y result stream three samples per 32-bit word and
// buffers the words in a small FIFO drained over valid/ready; overrun sets a sticky flag.
//
// state | meaning
// S0    | no slots filled
// S1    | slot0 holds one sample
// S2    | slot0 and slot1 hold two samples
module cs_y_packer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              y_valid,
    input  logic [9:0]        y,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } pack_state_t;

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    pack_state_t state;
    pack_state_t state_next;
    logic [9:0]  slot0;
    logic [9:0]  slot1;
    logic [9:0]  slot0_next;
    logic [9:0]  slot1_next;
    logic        push;
    logic [31:0] push_word;

    logic [31:0]     mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_q;
    logic              overflow_q;
    logic              full;
    logic              pop;
    logic              accept;

    // Packing FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            state <= state_next;
            slot0 <= slot0_next;
            slot1 <= slot1_next;
        end
    end

    // Slots are touched only when y_valid is high, so an unknown y never leaks in.
    always_comb begin
        state_next = state;
        slot0_next = slot0;
        slot1_next = slot1;
        push       = 1'b0;
        push_word  = '0;
        case (state)
            S0: begin
                if (y_valid && flush) begin
                    push      = 1'b1;
                    push_word = {2'b01, 20'd0, y};
                end else if (y_valid) begin
                    slot0_next = y;
                    state_next = S1;
                end
            end
            S1: begin
                if (y_valid && flush) begin
                    push       = 1'b1;
                    push_word  = {2'b10, 10'd0, y, slot0};
                    state_next = S0;
                end else if (y_valid) begin
                    slot1_next = y;
                    state_next = S2;
                end else if (flush) begin
                    push       = 1'b1;
                    push_word  = {2'b01, 20'd0, slot0};
                    state_next = S0;
                end
            end
            S2: begin
                // A sample in S2 always completes the word; flush adds nothing.
                if (y_valid) begin
                    push       = 1'b1;
                    push_word  = {2'b11, y, slot1, slot0};
                    state_next = S0;
                end else if (flush) begin
                    push       = 1'b1;
                    push_word  = {2'b10, 10'd0, slot1, slot0};
                    state_next = S0;
                end
            end
            default: begin
                state_next = S0;
            end
        endcase
    end

    assign full      = (level_q == FULL_LEVEL);
    assign out_valid = (level_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign accept    = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({accept, pop})
                2'b10:   level_q <= level_q + (ADDR_W + 1)'(1);
                2'b01:   level_q <= level_q - (ADDR_W + 1)'(1);
                default: level_q <= level_q;
            endcase
            if (push && !accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule
